// File: rtl/sram_req_adapter.sv
// sram_req_adapter: bridges a valid/ready request stream onto single-cycle
// SRAM strobes (1-cycle read latency) and returns one in-order response per
// request. A small response FIFO absorbs back-pressure. Credits are counted
// so that every accepted request always has a FIFO slot for its result.
module sram_req_adapter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned USER_EN    = 0,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned AW        = $clog2(NUM_WORDS),
  localparam int unsigned BW        = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // request stream
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  input  logic [USER_WIDTH-1:0] req_wuser_i,
  // SRAM wrapper side
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  output logic [USER_WIDTH-1:0] sram_wuser_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  input  logic [USER_WIDTH-1:0] sram_ruser_i,
  // response stream
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [USER_WIDTH-1:0] rsp_ruser_o
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RSP_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RSP_DEPTH);

  // Registered state
  logic          inflight;
  logic          inflight_we;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // FIFO storage
  logic                  fifo_we    [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_rdata [RSP_DEPTH];
  logic [USER_WIDTH-1:0] fifo_ruser [RSP_DEPTH];

  // Combinational control
  logic                  credit_ok;
  logic [CW:0]           credit_used;
  logic                  accept;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] res_rdata;
  logic [USER_WIDTH-1:0] res_ruser;

  // Credit check uses only registered state, so rsp_ready_i never reaches req_ready_o
  always_comb begin
    credit_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
    credit_ok   = (credit_used < DEPTH_LIM);
    req_ready_o = !rst_i && credit_ok;
    accept      = req_valid_i && req_ready_o;
  end

  // SRAM strobes: request fields pass straight through, zeroed during reset
  always_comb begin
    sram_req_o   = accept;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    sram_wuser_o = '0;
    if (!rst_i) begin
      sram_we_o    = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
      sram_be_o    = req_be_i;
      sram_wuser_o = (USER_EN != 0) ? req_wuser_i : '0;
    end
  end

  // Result of the request issued last cycle; writes return zero data/user
  always_comb begin
    res_rdata = inflight_we ? '0 : sram_rdata_i;
    res_ruser = ((USER_EN != 0) && !inflight_we) ? sram_ruser_i : '0;
  end

  // Push/pop decisions: an empty FIFO lets the result fall through when taken
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    pop        = !rst_i && !fifo_empty && rsp_ready_i;
    push       = !rst_i && inflight && !(fifo_empty && rsp_ready_i);
  end

  // Response mux: FIFO head when occupied, otherwise the fall-through result
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_we_o    = 1'b0;
    rsp_rdata_o = '0;
    rsp_ruser_o = '0;
    if (!rst_i) begin
      if (!fifo_empty) begin
        rsp_valid_o = 1'b1;
        rsp_we_o    = fifo_we[rd_ptr];
        rsp_rdata_o = fifo_rdata[rd_ptr];
        rsp_ruser_o = fifo_ruser[rd_ptr];
      end else if (inflight) begin
        rsp_valid_o = 1'b1;
        rsp_we_o    = inflight_we;
        rsp_rdata_o = res_rdata;
        rsp_ruser_o = res_ruser;
      end
    end
  end

  // Inflight tracking, FIFO pointers and occupancy count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_we <= req_we_i;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // FIFO payload storage; needs no reset because occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we[wr_ptr]    <= inflight_we;
      fifo_rdata[wr_ptr] <= res_rdata;
      fifo_ruser[wr_ptr] <= res_ruser;
    end
  end

  // Occupancy can never exceed depth and a full FIFO is never pushed without a pop
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (fifo_cnt <= DEPTH_CNT);
      assert (!(push && !pop && (fifo_cnt == DEPTH_CNT)));
    end
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter with a behavioural 1-cycle-latency SRAM
// behind each instance. Main instance uses defaults (USER_EN=0); a second
// narrow instance exercises user-bit passthrough with a deeper FIFO.
module tb_sram_req_adapter;

  localparam logic [63:0] ZERO = 64'd0;
  localparam logic [63:0] ONE  = 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // ---------------- main instance (defaults) ----------------
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [0:0]  req_wuser;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0]  sram_be;
  logic [0:0]  sram_wuser;
  logic [63:0] sram_rdata;
  logic [0:0]  sram_ruser;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [63:0] rsp_rdata;
  logic [0:0]  rsp_ruser;

  sram_req_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .req_wuser_i(req_wuser),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_wuser_o(sram_wuser),
    .sram_rdata_i(sram_rdata), .sram_ruser_i(sram_ruser),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .rsp_ruser_o(rsp_ruser)
  );

  // SRAM model: ruser tied high so USER_EN=0 gating is observable
  logic [63:0] mem [1024];
  assign sram_ruser = 1'b1;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // ---------------- user instance ----------------
  logic        u_req_valid, u_req_ready, u_req_we;
  logic [3:0]  u_req_addr;
  logic [15:0] u_req_wdata;
  logic [1:0]  u_req_be;
  logic [1:0]  u_req_wuser;
  logic        u_sram_req, u_sram_we;
  logic [3:0]  u_sram_addr;
  logic [15:0] u_sram_wdata;
  logic [1:0]  u_sram_be;
  logic [1:0]  u_sram_wuser;
  logic [15:0] u_sram_rdata;
  logic [1:0]  u_sram_ruser;
  logic        u_rsp_valid, u_rsp_ready, u_rsp_we;
  logic [15:0] u_rsp_rdata;
  logic [1:0]  u_rsp_ruser;

  sram_req_adapter #(
    .DATA_WIDTH(16), .USER_WIDTH(2), .USER_EN(1), .NUM_WORDS(16), .RSP_DEPTH(4)
  ) dut_u (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(u_req_valid), .req_ready_o(u_req_ready), .req_we_i(u_req_we),
    .req_addr_i(u_req_addr), .req_wdata_i(u_req_wdata), .req_be_i(u_req_be),
    .req_wuser_i(u_req_wuser),
    .sram_req_o(u_sram_req), .sram_we_o(u_sram_we), .sram_addr_o(u_sram_addr),
    .sram_wdata_o(u_sram_wdata), .sram_be_o(u_sram_be), .sram_wuser_o(u_sram_wuser),
    .sram_rdata_i(u_sram_rdata), .sram_ruser_i(u_sram_ruser),
    .rsp_valid_o(u_rsp_valid), .rsp_ready_i(u_rsp_ready), .rsp_we_o(u_rsp_we),
    .rsp_rdata_o(u_rsp_rdata), .rsp_ruser_o(u_rsp_ruser)
  );

  logic [15:0] u_mem  [16];
  logic [1:0]  u_umem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      u_mem[i]  = '0;
      u_umem[i] = '0;
    end
    u_sram_rdata = '0;
    u_sram_ruser = '0;
  end
  always @(posedge clk) begin
    if (u_sram_req) begin
      if (u_sram_we) begin
        for (int b = 0; b < 2; b++)
          if (u_sram_be[b]) u_mem[u_sram_addr][b*8 +: 8] <= u_sram_wdata[b*8 +: 8];
        u_umem[u_sram_addr] <= u_sram_wuser;
      end else begin
        u_sram_rdata <= u_mem[u_sram_addr];
        u_sram_ruser <= u_umem[u_sram_addr];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [9:0] a, input logic [63:0] d,
                         input logic [7:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; req_wuser = 1'b1; rsp_ready = 1'b1;
    u_req_valid = 1'b0; u_req_we = 1'b0; u_req_addr = '0; u_req_wdata = '0;
    u_req_be = '0; u_req_wuser = '0; u_rsp_ready = 1'b1;

    // Reset gating with a request offered
    repeat (2) @(negedge clk);
    set_req(1'b0, 10'd0, ZERO, 8'hFF);
    #1;
    chk("rst_req_ready", 64'(req_ready), ZERO);
    chk("rst_rsp_valid", 64'(rsp_valid), ZERO);
    chk("rst_sram_req",  64'(sram_req),  ZERO);
    chk("rst_sram_we_x", 64'(sram_we),   ZERO);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("idle_req_ready", 64'(req_ready), ONE);
    chk("idle_rsp_valid", 64'(rsp_valid), ZERO);

    // Write then read address 5
    @(negedge clk);
    set_req(1'b1, 10'd5, 64'hDEADBEEF_00000001, 8'hFF);
    #1;
    chk("t1_sram_req",   64'(sram_req),   ONE);
    chk("t1_sram_we",    64'(sram_we),    ONE);
    chk("t1_sram_addr",  64'(sram_addr),  64'd5);
    chk("t1_sram_wdata", sram_wdata,      64'hDEADBEEF_00000001);
    chk("t1_sram_wuser", 64'(sram_wuser), ZERO);
    @(negedge clk);
    set_req(1'b0, 10'd5, ZERO, 8'hFF);
    #1;
    chk("t1_wr_rsp_valid", 64'(rsp_valid), ONE);
    chk("t1_wr_rsp_we",    64'(rsp_we),    ONE);
    chk("t1_wr_rsp_rdata", rsp_rdata,      ZERO);
    chk("t1_rd_sram_we",   64'(sram_we),   ZERO);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rd_rsp_valid", 64'(rsp_valid), ONE);
    chk("t1_rd_rsp_we",    64'(rsp_we),    ZERO);
    chk("t1_rd_rsp_rdata", rsp_rdata,      64'hDEADBEEF_00000001);
    chk("t1_rd_rsp_ruser", 64'(rsp_ruser), ZERO);
    @(negedge clk);
    #1;
    chk("t1_drained", 64'(rsp_valid), ZERO);

    // Fill addresses 0..15, then read them back-to-back
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) set_req(1'b1, 10'(i), pat(i), 8'hFF);
      else idle();
      #1;
      if (i > 0) chk($sformatf("wr%0d_rsp_we", i - 1), 64'(rsp_valid & rsp_we), ONE);
    end
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) set_req(1'b0, 10'(i), ZERO, 8'hFF);
      else idle();
      #1;
      if (i < 16) chk($sformatf("rd%0d_ready", i), 64'(req_ready), ONE);
      if (i > 0) begin
        chk($sformatf("rd%0d_valid", i - 1), 64'(rsp_valid), ONE);
        chk($sformatf("rd%0d_rdata", i - 1), rsp_rdata, pat(i - 1));
      end
    end
    @(negedge clk);
    #1;
    chk("b2b_drained", 64'(rsp_valid), ZERO);

    // Back-pressure: only two reads accepted, head held stable
    rsp_ready = 1'b0;
    set_req(1'b0, 10'd10, ZERO, 8'hFF);
    #1;
    chk("bp0_sram_req", 64'(sram_req), ONE);
    @(negedge clk);
    set_req(1'b0, 10'd11, ZERO, 8'hFF);
    #1;
    chk("bp1_sram_req", 64'(sram_req), ONE);
    chk("bp1_rdata",    rsp_rdata,     pat(10));
    @(negedge clk);
    set_req(1'b0, 10'd12, ZERO, 8'hFF);
    #1;
    chk("bp2_req_ready", 64'(req_ready), ZERO);
    chk("bp2_sram_req",  64'(sram_req),  ZERO);
    chk("bp2_rdata",     rsp_rdata,      pat(10));
    @(negedge clk);
    #1;
    chk("bp3_req_ready", 64'(req_ready), ZERO);
    chk("bp3_valid",     64'(rsp_valid), ONE);
    chk("bp3_rdata",     rsp_rdata,      pat(10));
    chk("bp3_cnt",       64'(dut.fifo_cnt), 64'd2);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp4_req_ready", 64'(req_ready), ZERO);
    chk("bp4_rdata",     rsp_rdata,      pat(10));
    @(negedge clk);
    #1;
    chk("bp5_rdata",    rsp_rdata,     pat(11));
    chk("bp5_sram_req", 64'(sram_req), ONE);
    @(negedge clk);
    set_req(1'b0, 10'd13, ZERO, 8'hFF);
    #1;
    chk("bp6_rdata",    rsp_rdata,     pat(12));
    chk("bp6_sram_req", 64'(sram_req), ONE);
    @(negedge clk);
    idle();
    #1;
    chk("bp7_rdata", rsp_rdata, pat(13));
    @(negedge clk);
    #1;
    chk("bp_drained", 64'(rsp_valid), ZERO);

    // Partial write of low bytes over zero
    set_req(1'b1, 10'd3, ZERO, 8'hFF);
    @(negedge clk);
    set_req(1'b1, 10'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    @(negedge clk);
    set_req(1'b0, 10'd3, ZERO, 8'hFF);
    @(negedge clk);
    idle();
    #1;
    chk("pw_rsp_we",    64'(rsp_we), ZERO);
    chk("pw_rsp_rdata", rsp_rdata,   64'h00000000_FFFFFFFF);

    // User passthrough on the USER_EN=1 instance
    @(negedge clk);
    u_req_valid = 1'b1; u_req_we = 1'b1; u_req_addr = 4'd7;
    u_req_wdata = 16'hBEEF; u_req_be = 2'b11; u_req_wuser = 2'b10;
    #1;
    chk("u_sram_req",   64'(u_sram_req),   ONE);
    chk("u_sram_wuser", 64'(u_sram_wuser), 64'd2);
    @(negedge clk);
    u_req_we = 1'b0; u_req_wuser = 2'b00;
    #1;
    chk("u_wr_rsp_we",    64'(u_rsp_we),    ONE);
    chk("u_wr_rsp_ruser", 64'(u_rsp_ruser), ZERO);
    @(negedge clk);
    u_req_valid = 1'b0;
    #1;
    chk("u_rd_rsp_we",    64'(u_rsp_we),    ZERO);
    chk("u_rd_rsp_rdata", 64'(u_rsp_rdata), 64'hBEEF);
    chk("u_rd_rsp_ruser", 64'(u_rsp_ruser), 64'd2);

    // Reset while two responses are pending
    @(negedge clk);
    set_req(1'b1, 10'd20, 64'h12345678_9ABCDEF0, 8'hFF);
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 10'd20, ZERO, 8'hFF);
    #1;
    chk("rs_rd_accept", 64'(sram_req), ONE);
    @(negedge clk);
    idle();
    #1;
    chk("rs_pend_ready", 64'(req_ready), ZERO);
    chk("rs_pend_we",    64'(rsp_we),    ONE);
    @(negedge clk);
    chk("rs_pre_cnt", 64'(dut.fifo_cnt), 64'd2);
    rst = 1'b1;
    #1;
    chk("rs_in_valid", 64'(rsp_valid), ZERO);
    chk("rs_in_ready", 64'(req_ready), ZERO);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_post_valid", 64'(rsp_valid),    ZERO);
    chk("rs_post_ready", 64'(req_ready),    ONE);
    chk("rs_post_cnt",   64'(dut.fifo_cnt), ZERO);
    rsp_ready = 1'b1;
    set_req(1'b0, 10'd20, ZERO, 8'hFF);
    @(negedge clk);
    idle();
    #1;
    chk("rs_rd_valid", 64'(rsp_valid), ONE);
    chk("rs_rd_we",    64'(rsp_we),    ZERO);
    chk("rs_rd_rdata", rsp_rdata,      64'h12345678_9ABCDEF0);
    @(negedge clk);
    #1;
    chk("rs_drained", 64'(rsp_valid), ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Converts a valid/ready request stream into the single-cycle `req/we/addr/be` strobes of the single-port SRAM macro wrapper (1-cycle read latency, no output registers).
- Returns every request's result as an in-order valid/ready response stream.
- Holds SRAM read data in a small response FIFO, so response back-pressure never loses data.
- Sits between a cache/bus master and the SRAM wrapper.

Parameters:
- DATA_WIDTH, 64: data width of request, SRAM and response.
- USER_WIDTH, 1: user sideband width.
- USER_EN, 0: 1 passes user bits through; 0 drives all user outputs to 0.
- NUM_WORDS, 1024: SRAM depth; address width AW = $clog2(NUM_WORDS).
- RSP_DEPTH, 2: response FIFO entries; power of two, at least 2.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset.
- req_valid_i, input, 1: request valid.
- req_ready_o, output, 1: request ready.
- req_we_i, input, 1: 1 = write, 0 = read.
- req_addr_i, input, AW: word address.
- req_wdata_i, input, DATA_WIDTH: write data.
- req_be_i, input, (DATA_WIDTH+7)/8: byte enables.
- req_wuser_i, input, USER_WIDTH: write user bits.
- sram_req_o, output, 1: SRAM request strobe.
- sram_we_o, output, 1: SRAM write enable.
- sram_addr_o, output, AW: SRAM address.
- sram_wdata_o, output, DATA_WIDTH: SRAM write data.
- sram_be_o, output, (DATA_WIDTH+7)/8: SRAM byte enables.
- sram_wuser_o, output, USER_WIDTH: SRAM write user bits.
- sram_rdata_i, input, DATA_WIDTH: SRAM read data, valid the cycle after a read strobe.
- sram_ruser_i, input, USER_WIDTH: SRAM read user bits, same timing as sram_rdata_i.
- rsp_valid_o, output, 1: response valid.
- rsp_ready_i, input, 1: response ready.
- rsp_we_o, output, 1: response belongs to a write.
- rsp_rdata_o, output, DATA_WIDTH: read data.
- rsp_ruser_o, output, USER_WIDTH: read user bits.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- While rst_i is high: flush the FIFO, clear inflight; req_ready_o=0, rsp_valid_o=0, sram_req_o=0. Data outputs are don't-care but must be X-free (drive 0).
- State: inflight flag, inflight_we bit, FIFO of {we, rdata, ruser} with count fifo_cnt (0..RSP_DEPTH).
- Credit rule: req_ready_o = (fifo_cnt + inflight < RSP_DEPTH).
  - Depends only on registered state; there is no combinational path from rsp_ready_i to req_ready_o.
- Accept: a request is accepted in cycle t when req_valid_i & req_ready_o.
  - sram_req_o = accept (combinational).
  - sram_we/addr/wdata/be pass req_* through combinationally.
  - sram_wuser_o = USER_EN ? req_wuser_i : 0.
- Inflight: set at the end of cycle t, with inflight_we = req_we_i. Cleared at the end of cycle t+1 unless a new request is accepted in t+1, in which case it stays set.
- Result in cycle t+1 (inflight=1):
  - Result = {inflight_we, sram_rdata_i, USER_EN ? sram_ruser_i : 0}.
  - For writes, rdata and ruser are forced to 0.
- Fall-through: if fifo_cnt==0 and inflight, the result drives rsp_* directly and rsp_valid_o=1. Read latency is therefore 1 cycle.
  - If rsp_ready_i=1, the result is consumed and nothing is stored.
  - Otherwise it is pushed into the FIFO.
- FIFO non-empty: rsp_* come from the FIFO head.
  - rsp_ready_i=1 pops the head.
  - An inflight result is pushed in the same cycle. Simultaneous push and pop leave fifo_cnt unchanged.
- Overflow is impossible by the credit rule; assert fifo_cnt <= RSP_DEPTH.
- Throughput: with rsp_ready_i held at 1, one request per cycle indefinitely.
- Ordering: responses return strictly in request order, reads and writes alike. Each accepted request produces exactly one response.
- Response stability: once rsp_valid_o=1 and rsp_ready_i=0, the rsp_* outputs hold stable until the handshake completes.
  - Met because a fall-through result is captured into the FIFO head.
- FIFO pointers wrap modulo RSP_DEPTH.
- Reset mid-operation drops all pending and inflight responses. The SRAM content written before reset is kept.

Test Plan:
- Write 0xDEADBEEF_00000001 to address 5 (be=0xFF), then read address 5, rsp_ready_i=1 → two responses:
  - First: rsp_we_o=1, rdata=0.
  - Second: cycle after the read accept, rsp_we_o=0, rdata=0xDEADBEEF_00000001.
- Back-to-back reads of addresses 0..15 with rsp_ready_i=1 → req_ready_o stays 1, 16 in-order responses, one per cycle, no gaps.
- Hold rsp_ready_i=0 and issue 4 reads → exactly 2 accepted, then req_ready_o=0. rsp_valid_o=1 with stable data.
  - Release rsp_ready_i → the two responses drain in order, then the next requests are accepted.
- Partial write be=0x0F of 0xFFFFFFFF_FFFFFFFF over 0 at address 3, then read → rdata=0x00000000_FFFFFFFF.
- USER_EN=0 with wuser=1 → sram_wuser_o=0 and rsp_ruser_o=0.
  - USER_EN=1 → ruser returned equals the written wuser.
- Assert rst_i for 1 cycle while 2 responses are pending:
  - Next cycle: rsp_valid_o=0, fifo_cnt=0, req_ready_o=1.
  - A following read returns the data written before reset.
